// File: rtl/dma_rd_if.sv
`default_nettype none
// ------------------------------------------------------------------
// dma_rd_if : AXI4 read-address and read-data channels of the read DMA
// Revision  : 1.0
// ------------------------------------------------------------------
interface dma_rd_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 8
);
  logic [AXI_ID_WIDTH-1:0]   m_axi_arid;
  logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]                m_axi_arlen;
  logic [2:0]                m_axi_arsize;
  logic [1:0]                m_axi_arburst;
  logic                      m_axi_arlock;
  logic [3:0]                m_axi_arcache;
  logic [2:0]                m_axi_arprot;
  logic                      m_axi_arvalid;
  logic                      m_axi_arready;
  logic [AXI_ID_WIDTH-1:0]   m_axi_rid;
  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]                m_axi_rresp;
  logic                      m_axi_rlast;
  logic                      m_axi_rvalid;
  logic                      m_axi_rready;

  modport master (
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid, m_axi_rready,
    input  m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
  );

  modport slave (
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid, m_axi_rready,
    output m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
  );
endinterface
`default_nettype wire

// File: rtl/dma_rd.sv
`default_nettype none
// ------------------------------------------------------------------
// dma_rd   : AXI4 read-master DMA; queued (addr,len) commands become
//            4 KB-safe INCR bursts whose data is forwarded as a stream
// Revision : 1.0
// ------------------------------------------------------------------
module dma_rd #(
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int AXI_ADDR_WIDTH    = 32,
  parameter int AXI_ID_WIDTH      = 8,
  parameter int CONFIG_LEN_WIDTH  = 9,
  parameter int OUTSTANDING_COUNT = 2,
  parameter int MAX_BURST         = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  dma_rd_if.master                    axi,
  output logic [AXI_DATA_WIDTH-1:0]   data_out,
  output logic                        valid_out,
  output logic                        last_out,
  input  logic                        ready_in,
  input  logic                        config_valid,
  output logic                        config_ready,
  output logic                        config_empty,
  input  logic [CONFIG_LEN_WIDTH-1:0] config_len,
  input  logic [AXI_ADDR_WIDTH-1:0]   config_addr,
  output logic                        err
);

  localparam int BYTES  = AXI_DATA_WIDTH / 8;
  localparam int BSHIFT = $clog2(BYTES);
  localparam int PTR_W  = (OUTSTANDING_COUNT > 1) ? $clog2(OUTSTANDING_COUNT) : 1;
  localparam int CNT_W  = $clog2(OUTSTANDING_COUNT + 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(BYTES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t                      state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [CONFIG_LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [8:0]                  burst_q, burst_d;
  logic                        arvalid_q, arvalid_d;
  logic [AXI_DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                        valid_out_q, valid_out_d;
  logic                        last_out_q, last_out_d;
  logic                        err_q, err_d;

  logic [AXI_ADDR_WIDTH-1:0]   q_addr_q [OUTSTANDING_COUNT];
  logic [AXI_ADDR_WIDTH-1:0]   q_addr_d [OUTSTANDING_COUNT];
  logic [CONFIG_LEN_WIDTH-1:0] q_len_q  [OUTSTANDING_COUNT];
  logic [CONFIG_LEN_WIDTH-1:0] q_len_d  [OUTSTANDING_COUNT];
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;

  logic                        q_empty, q_full, push, pop, ar_hs, r_hs, rready;
  logic [AXI_ADDR_WIDTH-1:0]   head_addr;
  logic [CONFIG_LEN_WIDTH-1:0] head_len;
  logic                        unused_rid;

  // Largest burst allowed by remaining length, burst cap and distance to the 4 KB page end.
  function automatic logic [8:0] calc_burst(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                            input logic [CONFIG_LEN_WIDTH-1:0] rem);
    logic [12:0] room;
    logic [31:0] b;
    room = (13'd4096 - {1'b0, addr[11:0]}) >> BSHIFT;
    b    = 32'(MAX_BURST);
    if (32'(rem) < b)  b = 32'(rem);
    if (32'(room) < b) b = 32'(room);
    return b[8:0];
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(OUTSTANDING_COUNT - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign q_empty      = (count_q == '0);
  assign q_full       = (count_q == CNT_W'(OUTSTANDING_COUNT));
  assign pop          = (state_q == IDLE) && !q_empty;
  assign config_ready = !q_full || pop;
  assign push         = config_valid && config_ready;
  assign head_addr    = q_addr_q[rd_ptr_q] & ALIGN_MASK;
  assign head_len     = q_len_q[rd_ptr_q];
  assign ar_hs        = arvalid_q && axi.m_axi_arready;
  assign rready       = (state_q == DATA) && (!valid_out_q || ready_in);
  assign r_hs         = axi.m_axi_rvalid && rready;
  assign unused_rid   = ^axi.m_axi_rid;

  assign axi.m_axi_arid    = '0;
  assign axi.m_axi_araddr  = cur_addr_q;
  assign axi.m_axi_arlen   = 8'(burst_q - 9'd1);
  assign axi.m_axi_arsize  = 3'(BSHIFT);
  assign axi.m_axi_arburst = 2'b01;
  assign axi.m_axi_arlock  = 1'b0;
  assign axi.m_axi_arcache = 4'b0011;
  assign axi.m_axi_arprot  = 3'b000;
  assign axi.m_axi_arvalid = arvalid_q;
  assign axi.m_axi_rready  = rready;

  assign data_out     = data_out_q;
  assign valid_out    = valid_out_q;
  assign last_out     = last_out_q;
  assign err          = err_q;
  assign config_empty = q_empty && (state_q == IDLE) && !valid_out_q;

  always_comb begin
    q_addr_d = q_addr_q;
    q_len_d  = q_len_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // When full, a push overwrites the slot being popped this cycle; the head is already read.
    if (push) begin
      q_addr_d[wr_ptr_q] = config_addr;
      q_len_d[wr_ptr_q]  = config_len;
      wr_ptr_d           = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    burst_d     = burst_q;
    arvalid_d   = arvalid_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    last_out_d  = last_out_q;
    err_d       = err_q || (r_hs && (axi.m_axi_rresp != 2'b00));

    if (r_hs) begin
      data_out_d  = axi.m_axi_rdata;
      valid_out_d = 1'b1;
      last_out_d  = axi.m_axi_rlast && (remaining_q == '0);
    end else if (ready_in) begin
      valid_out_d = 1'b0;
      last_out_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pop) begin
          cur_addr_d  = head_addr;
          remaining_d = head_len;
          if (head_len != '0) begin
            state_d   = ADDR;
            arvalid_d = 1'b1;
            burst_d   = calc_burst(head_addr, head_len);
          end
        end
      end
      ADDR: begin
        if (ar_hs) begin
          cur_addr_d  = cur_addr_q + (AXI_ADDR_WIDTH'(burst_q) << BSHIFT);
          remaining_d = remaining_q - CONFIG_LEN_WIDTH'(burst_q);
          arvalid_d   = 1'b0;
          state_d     = DATA;
        end
      end
      DATA: begin
        if (r_hs && axi.m_axi_rlast) begin
          if (remaining_q != '0) begin
            state_d   = ADDR;
            arvalid_d = 1'b1;
            burst_d   = calc_burst(cur_addr_q, remaining_q);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      burst_q     <= 9'd1;
      arvalid_q   <= 1'b0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < OUTSTANDING_COUNT; i++) begin
        q_addr_q[i] <= '0;
        q_len_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      burst_q     <= burst_d;
      arvalid_q   <= arvalid_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      last_out_q  <= last_out_d;
      err_q       <= err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      q_addr_q    <= q_addr_d;
      q_len_q     <= q_len_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/dma_rd.md
Name: dma_rd

Overview:
- AXI4 read-master DMA, the read-side counterpart of the write DMA.
- Accepts (addr, len) commands into a small command queue and splits each command into INCR bursts that respect the burst cap and 4 KB boundaries.
- Issues AR bursts and forwards R data to the next stage as a valid/ready stream; last_out marks the final beat of each command.
- Sits between the AXI interconnect and the datapath consumer.

Parameters:
- AXI_DATA_WIDTH, 32, R data / stream width in bits (power of 2, >= 8).
- AXI_ADDR_WIDTH, 32, address width.
- AXI_ID_WIDTH, 8, ARID width; ARID is constant 0.
- CONFIG_LEN_WIDTH, 9, command length width in beats (data words).
- OUTSTANDING_COUNT, 2, command queue depth.
- MAX_BURST, 16, maximum beats per AR burst (1..256).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m_axi_arid  out  AXI_ID_WIDTH  constant 0
- m_axi_araddr  out  AXI_ADDR_WIDTH  burst start address
- m_axi_arlen  out  8  beats-1
- m_axi_arsize  out  3  log2(AXI_DATA_WIDTH/8)
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arlock  out  1  constant 0
- m_axi_arcache  out  4  constant 4'b0011
- m_axi_arprot  out  3  constant 0
- m_axi_arvalid  out  1  AR valid
- m_axi_arready  in  1  AR ready
- m_axi_rid  in  AXI_ID_WIDTH  ignored
- m_axi_rdata  in  AXI_DATA_WIDTH  read data
- m_axi_rresp  in  2  read response
- m_axi_rlast  in  1  last beat of burst
- m_axi_rvalid  in  1  R valid
- m_axi_rready  out  1  R ready
- data_out  out  AXI_DATA_WIDTH  stream data
- valid_out  out  1  stream valid
- last_out  out  1  final beat of current command
- ready_in  in  1  downstream ready
- config_valid  in  1  command push
- config_ready  out  1  queue can accept
- config_empty  out  1  queue empty, FSM IDLE, output register empty
- config_len  in  CONFIG_LEN_WIDTH  beats to read
- config_addr  in  AXI_ADDR_WIDTH  start byte address
- err  out  1  sticky: any rresp != 0

Behaviour:
- Reset: arvalid=0, rready=0, valid_out=0, last_out=0, data_out=0, err=0, config_ready=1, config_empty=1, FSM=IDLE, queue empty.
- Command queue: FIFO of {addr,len}, depth OUTSTANDING_COUNT.
  - Push on config_valid && config_ready.
  - config_ready = ~full || pop; simultaneous push and pop when full is legal.
  - Push while config_ready=0 is dropped; the bench must not do it.
- Address: the low log2(bytes) bits of config_addr are forced to 0 on load.
- FSM IDLE:
  - When the queue is non-empty, pop the head and load cur_addr and remaining=len.
  - If len==0, the command is discarded with no AXI or stream activity; stay in IDLE.
  - Otherwise go to ADDR on the next cycle.
- FSM ADDR:
  - burst = min(remaining, MAX_BURST, (4096 - cur_addr[11:0]) >> log2(bytes)).
  - Drive araddr=cur_addr, arlen=burst-1 and arvalid=1, held stable until arready.
  - On handshake: cur_addr += burst*bytes, remaining -= burst, go to DATA.
- FSM DATA:
  - Exactly one burst is outstanding.
  - Each R handshake loads the output register.
  - On the rlast handshake: go to ADDR if remaining>0, else IDLE.
  - A new command may pop in the IDLE cycle that follows.
- Output register (one-entry pipeline):
  - m_axi_rready = (FSM==DATA) && (~valid_out || ready_in).
  - On an R handshake: data_out=rdata, valid_out=1, last_out = rlast && remaining==0.
  - Without an R handshake, valid_out clears on ready_in.
  - Latency: one cycle from the R handshake to valid_out.
  - Full throughput with ready_in held high.
- rlast is taken from the interconnect. A beat-count mismatch against arlen is not checked.
- err is set on any R handshake with rresp != 2'b00 and cleared only by reset. Data is forwarded regardless of err.
- config_empty = queue empty && FSM==IDLE && ~valid_out.
- Reset mid-transfer aborts everything immediately and all state returns to reset values. Outstanding AXI beats after reset are the system's responsibility.

Test Plan:
- Cmd addr=0x1000, len=4, ready_in=1, zero-wait slave -> one AR (araddr=0x1000, arlen=3, arsize=2, arburst=1); 4 stream beats with last_out only on beat 4; config_empty returns to 1.
- Cmd addr=0x0, len=40, MAX_BURST=16 -> three ARs: 0x0 with arlen=15, 0x40 with arlen=15, 0x80 with arlen=7; 40 beats with a single last_out.
- Cmd addr=0x0FF8, len=8 -> two ARs: 0x0FF8 with arlen=1, then 0x1000 with arlen=5; no 4 KB crossing.
- Two back-to-back cmds pushed while busy plus a third push with the queue full -> config_ready=0 until the pop; both queued commands complete in order with separate last_out.
- ready_in toggling 1,0,0,1 during a burst -> rready drops while the output is held, no beat lost or duplicated, data order preserved.
- rresp=2'b10 on beat 2 of 4 -> err=1 from the next cycle and stays 1; all 4 beats are delivered. Cmd len=0 -> no AR issued, config_empty=1.
